ceas_alarma: RTL and testbench

Real-time clock and alarm stage fed directly by the time/alarm setting block. It keeps the running time (hours, minutes, seconds) from a prescaled system clock, accepts new time or alarm values on the setting block's one-cycle load strobes, and drives the buzzer output when the running time reaches the stored alarm. Its outputs feed the display multiplexer and the buzzer driver.

---
 rtl/ceas_alarma.sv | 139 +++++++++++++
 tb/tb_ceas_alarma.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ceas_alarma.sv
// Real-time clock (hh:mm:ss) with a single daily alarm.
// The buzzer rings on the rising edge of a time/alarm match and stops on alarm_off or after RING_SECONDS.
module ceas_alarma #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned RING_SECONDS  = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] ore,
    input  logic [5:0] minute,
    input  logic       load_timp,
    input  logic       load_alarma,
    input  logic       alarm_off,
    output logic [4:0] ore_ceas,
    output logic [5:0] minute_ceas,
    output logic [5:0] secunde,
    output logic       tick_sec,
    output logic       sonerie,
    output logic       armed
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam int unsigned RW = $clog2(RING_SECONDS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        RINGING
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [RW-1:0] ring_cnt;
    logic [RW-1:0] ring_cnt_nxt;
    logic [4:0]    alarm_h;
    logic [5:0]    alarm_m;
    logic          match;
    logic          match_q;
    logic [4:0]    ore_ok;
    logic [5:0]    minute_ok;

    // Out-of-range fields from the setting stage are stored as zero.
    assign ore_ok    = (ore > 5'd23)    ? '0 : ore;
    assign minute_ok = (minute > 6'd59) ? '0 : minute;

    assign tick_sec = (presc == PRESC_MAX);
    assign match    = (ore_ceas == alarm_h) && (minute_ceas == alarm_m);

    always_ff @(posedge clock) begin
        if (reset) begin
            presc       <= '0;
            secunde     <= '0;
            minute_ceas <= '0;
            ore_ceas    <= '0;
        end else if (load_timp) begin
            presc       <= '0;
            secunde     <= '0;
            minute_ceas <= minute_ok;
            ore_ceas    <= ore_ok;
        end else begin
            presc <= tick_sec ? '0 : presc + PW'(1);
            if (tick_sec) begin
                if (secunde == 6'd59) begin
                    secunde <= '0;
                    if (minute_ceas == 6'd59) begin
                        minute_ceas <= '0;
                        ore_ceas    <= (ore_ceas == 5'd23) ? '0 : ore_ceas + 5'd1;
                    end else begin
                        minute_ceas <= minute_ceas + 6'd1;
                    end
                end else begin
                    secunde <= secunde + 6'd1;
                end
            end
        end
    end

    // Forcing match_q on an alarm load suppresses a ring for the minute already showing.
    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_h <= '0;
            alarm_m <= '0;
            match_q <= 1'b0;
        end else if (load_alarma) begin
            alarm_h <= ore_ok;
            alarm_m <= minute_ok;
            match_q <= 1'b1;
        end else begin
            match_q <= match;
        end
    end

    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
        case (state)
            DISARMED: begin
                if (load_alarma) state_nxt = ARMED;
            end
            ARMED: begin
                if (load_alarma) begin
                    state_nxt = ARMED;
                end else if (alarm_off) begin
                    state_nxt = DISARMED;
                end else if (match && !match_q) begin
                    state_nxt    = RINGING;
                    ring_cnt_nxt = '0;
                end
            end
            RINGING: begin
                if (load_alarma || alarm_off) begin
                    state_nxt = ARMED;
                end else if (tick_sec) begin
                    ring_cnt_nxt = ring_cnt + RW'(1);
                    if (ring_cnt == RING_LAST) state_nxt = ARMED;
                end
            end
            default: state_nxt = DISARMED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= DISARMED;
            ring_cnt <= '0;
            sonerie  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_cnt_nxt;
            sonerie  <= (state_nxt == RINGING);
            armed    <= (state_nxt != DISARMED);
        end
    end

endmodule

// File: tb/tb_ceas_alarma.sv
// Directed bench for ceas_alarma with TICKS_PER_SEC=4, RING_SECONDS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ceas_alarma;

    logic       clock;
    logic       reset;
    logic [4:0] ore;
    logic [5:0] minute;
    logic       load_timp;
    logic       load_alarma;
    logic       alarm_off;
    logic [4:0] ore_ceas;
    logic [5:0] minute_ceas;
    logic [5:0] secunde;
    logic       tick_sec;
    logic       sonerie;
    logic       armed;

    int vectors = 0;
    int miscompares = 0;

    ceas_alarma #(
        .TICKS_PER_SEC(4),
        .RING_SECONDS (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ore        (ore),
        .minute     (minute),
        .load_timp  (load_timp),
        .load_alarma(load_alarma),
        .alarm_off  (alarm_off),
        .ore_ceas   (ore_ceas),
        .minute_ceas(minute_ceas),
        .secunde    (secunde),
        .tick_sec   (tick_sec),
        .sonerie    (sonerie),
        .armed      (armed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] tval(input int h, input int m, input int s);
        return 32'(h * 4096 + m * 64 + s);
    endfunction

    function automatic logic [31:0] now();
        return 32'({ore_ceas, minute_ceas, secunde});
    endfunction

    initial begin
        reset       = 1'b1;
        ore         = '0;
        minute      = '0;
        load_timp   = 1'b0;
        load_alarma = 1'b0;
        alarm_off   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("rst_time", now(), tval(0, 0, 0));
        check("rst_tick", 32'(tick_sec), 32'd0);
        check("rst_sonerie", 32'(sonerie), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);

        // Free run: one tick every 4th cycle, 60 ticks roll into minute 1.
        for (int i = 1; i <= 240; i++) begin
            cyc();
            check("run_tick", 32'(tick_sec), 32'((i % 4) == 3));
            if (i == 236) check("run_sec59", now(), tval(0, 0, 59));
        end
        check("run_min1", now(), tval(0, 1, 0));

        // Day rollover from 23:59.
        load_timp = 1'b1; ore = 5'd23; minute = 6'd59;
        cyc();
        load_timp = 1'b0;
        check("load_2359", now(), tval(23, 59, 0));
        for (int i = 1; i <= 240; i++) begin
            cyc();
            check("rollover", now(), (i == 240) ? tval(0, 0, 0) : tval(23, 59, i / 4));
        end

        // Alarm at 07:00 reached from 06:59, then auto-stop after 3 ticks.
        load_alarma = 1'b1; ore = 5'd7; minute = 6'd0;
        cyc();
        load_alarma = 1'b0;
        check("arm_armed", 32'(armed), 32'd1);
        check("arm_sonerie", 32'(sonerie), 32'd0);
        load_timp = 1'b1; ore = 5'd6; minute = 6'd59;
        cyc();
        load_timp = 1'b0;
        check("load_0659", now(), tval(6, 59, 0));
        for (int i = 1; i <= 256; i++) begin
            cyc();
            if (i == 240) check("time_0700", now(), tval(7, 0, 0));
            check("ring_sonerie", 32'(sonerie), 32'(i >= 241 && i < 252));
            check("ring_armed", 32'(armed), 32'd1);
        end
        check("after_ring_time", now(), tval(7, 0, 4));

        // Ring via a time load, then alarm_off twice.
        load_alarma = 1'b1; ore = 5'd8; minute = 6'd0;
        cyc();
        load_alarma = 1'b0;
        check("arm8_armed", 32'(armed), 32'd1);
        load_timp = 1'b1; ore = 5'd8; minute = 6'd0;
        cyc();
        load_timp = 1'b0;
        check("load_0800", now(), tval(8, 0, 0));
        check("load_0800_son", 32'(sonerie), 32'd0);
        cyc();
        check("tl_ring", 32'(sonerie), 32'd1);
        alarm_off = 1'b1;
        cyc();
        alarm_off = 1'b0;
        check("off1_sonerie", 32'(sonerie), 32'd0);
        check("off1_armed", 32'(armed), 32'd1);
        cyc();
        check("off1_hold_son", 32'(sonerie), 32'd0);
        alarm_off = 1'b1;
        cyc();
        alarm_off = 1'b0;
        check("off2_armed", 32'(armed), 32'd0);
        check("off2_sonerie", 32'(sonerie), 32'd0);

        // Alarm equal to current time must not ring.
        load_alarma = 1'b1; ore = 5'd8; minute = 6'd0;
        cyc();
        load_alarma = 1'b0;
        check("same_armed", 32'(armed), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("same_noring", 32'(sonerie), 32'd0);
        end

        // Out-of-range time load.
        load_timp = 1'b1; ore = 5'd25; minute = 6'd61;
        cyc();
        load_timp = 1'b0;
        check("oor_time", now(), tval(0, 0, 0));
        cyc();
        cyc();
        cyc();
        check("pre_tick", 32'(tick_sec), 32'd1);

        // Load coinciding with a tick discards the tick and restarts the prescaler.
        load_timp = 1'b1; ore = 5'd10; minute = 6'd30;
        cyc();
        load_timp = 1'b0;
        check("tick_load_time", now(), tval(10, 30, 0));
        check("tick_load_tick", 32'(tick_sec), 32'd0);
        cyc();
        cyc();
        check("tick_load_t2", 32'(tick_sec), 32'd0);
        cyc();
        check("tick_load_t3", 32'(tick_sec), 32'd1);

        // Out-of-range alarm stores 00:00; ring it, then reset mid-ring.
        load_alarma = 1'b1; ore = 5'd30; minute = 6'd63;
        cyc();
        load_alarma = 1'b0;
        check("oor_alarm_armed", 32'(armed), 32'd1);
        load_timp = 1'b1; ore = 5'd0; minute = 6'd0;
        cyc();
        load_timp = 1'b0;
        check("oor_alarm_pre", 32'(sonerie), 32'd0);
        cyc();
        check("oor_alarm_ring", 32'(sonerie), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_time", now(), tval(0, 0, 0));
        check("mid_rst_tick", 32'(tick_sec), 32'd0);
        check("mid_rst_sonerie", 32'(sonerie), 32'd0);
        check("mid_rst_armed", 32'(armed), 32'd0);
        cyc();
        check("post_rst_sonerie", 32'(sonerie), 32'd0);
        check("post_rst_armed", 32'(armed), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
